// File: rtl/wm_ctrl_pkg.sv
// Purpose : shared types and default widths for the conv weight-memory controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, default parameter values, flag-bundle width.
package wm_ctrl_pkg;

  localparam int WM_DW_DEF     = 512;  // weight word width
  localparam int WM_AW_DEF     = 8;    // RAM address width
  localparam int WM_DEPTH_DEF  = 242;  // words per layer
  localparam int WM_RD_LAT_DEF = 2;    // RAM port-B read latency
  localparam int WM_PW_DEF     = 16;   // pass-count width

  // Flags carried alongside each issued read address: {valid, last, done}
  localparam int WM_FLAG_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LOADED = 3'd2,
    READ   = 3'd3,
    DRAIN  = 3'd4
  } wm_state_t;

endpackage

// File: rtl/wm_rd_pipe.sv
// Purpose : delay line that aligns read-issue flags with RAM port-B data.
// Latency : exactly RD_LAT cycles from in_* to out_*.
// Backpressure: none; shifts every cycle.
// Ports   : clk, rst_n; in_valid/in_last/in_done -> out_valid/out_last/out_done.
module wm_rd_pipe
  import wm_ctrl_pkg::*;
#(
  parameter int RD_LAT = WM_RD_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  input  logic in_done,
  output logic out_valid,
  output logic out_last,
  output logic out_done
);

  logic [WM_FLAG_W-1:0] stage [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= {in_valid, in_last, in_done};
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_valid = stage[RD_LAT-1][2];
  assign out_last  = stage[RD_LAT-1][1];
  assign out_done  = stage[RD_LAT-1][0];

endmodule

// File: rtl/conv_wm_ctrl.sv
// Purpose : sequences a per-layer weight RAM: loads a weight stream into port A,
//           then replays the whole RAM num_pass times through port B.
// Latency : wt_valid follows each issued ram_addrb by RD_LAT cycles; start to
//           wt_done is DEPTH*num_pass + RD_LAT cycles.
// Backpressure: load stream via ld_valid/ld_ready; replay has none (consumer must keep up).
// Optional: CONV_WM_CTRL_STATS_EN adds ld_cnt and pass_done_cnt outputs.
// Ports   : load stream (load_req, ld_*), replay control (start, num_pass),
//           RAM port A (ram_wea/addra/dina), port B (ram_addrb/doutb),
//           compute-array stream (wt_*), status (loaded, busy).
module conv_wm_ctrl
  import wm_ctrl_pkg::*;
#(
  parameter int DW     = WM_DW_DEF,
  parameter int AW     = WM_AW_DEF,
  parameter int DEPTH  = WM_DEPTH_DEF,
  parameter int RD_LAT = WM_RD_LAT_DEF,
  parameter int PW     = WM_PW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  input  logic [PW-1:0] num_pass,
  output logic          ram_wea,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  output logic [AW-1:0] ram_addrb,
  input  logic [DW-1:0] ram_doutb,
  output logic          wt_valid,
  output logic [DW-1:0] wt_data,
  output logic          wt_last,
  output logic          wt_done,
  output logic          loaded,
  output logic          busy
`ifdef CONV_WM_CTRL_STATS_EN
  ,
  output logic [AW:0]   ld_cnt,
  output logic [31:0]   pass_done_cnt
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam int            DRW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DRW-1:0] DRAIN_END = DRW'(RD_LAT - 1);

  wm_state_t      state;
  logic [AW-1:0]  wr_ptr;
  logic [PW-1:0]  pass_cnt;
  logic [PW-1:0]  pass_final;   // index of the last pass (num_pass-1, min 0)
  logic [DRW-1:0] drain_cnt;

  logic wr_fire;
  logic iss_valid;
  logic iss_last;
  logic iss_done;
  logic load_accept;

  // Write side: handshake drives port A directly so a word lands in the
  // same cycle it is accepted.
  assign wr_fire   = ld_valid && ld_ready;
  assign ram_wea   = wr_fire;
  assign ram_addra = wr_ptr;
  assign ram_dina  = wr_fire ? ld_data : '0;

  // Read side: the registered ram_addrb is the address issued this cycle.
  assign iss_valid = (state == READ);
  assign iss_last  = iss_valid && (ram_addrb == LAST_ADDR);
  assign iss_done  = iss_last && (pass_cnt == pass_final);

  // load_req is honoured only where a (re)load is legal.
  assign load_accept = load_req && ((state == IDLE) || (state == LOADED));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ld_ready   <= 1'b0;
      loaded     <= 1'b0;
      busy       <= 1'b0;
      wr_ptr     <= '0;
      ram_addrb  <= '0;
      pass_cnt   <= '0;
      pass_final <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_req) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            wr_ptr   <= '0;
          end
        end

        LOAD: begin
          if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (wr_ptr == LAST_ADDR) begin
              state    <= LOADED;
              ld_ready <= 1'b0;
              loaded   <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        LOADED: begin
          // load_req has priority; a coincident start is dropped.
          if (load_req) begin
            state    <= LOAD;
            loaded   <= 1'b0;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            wr_ptr   <= '0;
          end else if (start) begin
            state      <= READ;
            busy       <= 1'b1;
            ram_addrb  <= '0;
            pass_cnt   <= '0;
            pass_final <= (num_pass == '0) ? '0 : (num_pass - PW'(1));
          end
        end

        READ: begin
          if (iss_last) begin
            ram_addrb <= '0;
            pass_cnt  <= pass_cnt + PW'(1);
            if (iss_done) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            ram_addrb <= ram_addrb + AW'(1);
          end
        end

        DRAIN: begin
          // Hold off new commands until the last word has left the pipe.
          if (drain_cnt == DRAIN_END) begin
            state <= LOADED;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DRW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
          loaded   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  wm_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iss_valid),
    .in_last   (iss_last),
    .in_done   (iss_done),
    .out_valid (wt_valid),
    .out_last  (wt_last),
    .out_done  (wt_done)
  );

  // RAM data is forwarded unregistered; masked outside valid words so the
  // bus is quiet when nothing is being replayed.
  assign wt_data = wt_valid ? ram_doutb : '0;

`ifdef CONV_WM_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt        <= '0;
      pass_done_cnt <= '0;
    end else begin
      if (load_accept) begin
        ld_cnt <= '0;
      end else if (wr_fire) begin
        ld_cnt <= ld_cnt + (AW+1)'(1);
      end
      if (wt_valid && wt_last) begin
        pass_done_cnt <= pass_done_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_wm_ctrl.sv
module tb_conv_wm_ctrl;

  localparam int DW    = 512;
  localparam int AW    = 8;
  localparam int DEPTH = 242;
  localparam int PW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_req, ld_valid, ld_ready, start;
  logic [DW-1:0] ld_data;
  logic [PW-1:0] num_pass;
  logic          ram_wea;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb, wt_data;
  logic          wt_valid, wt_last, wt_done, loaded, busy;
`ifdef CONV_WM_CTRL_STATS_EN
  logic [AW:0]   ld_cnt;
  logic [31:0]   pass_done_cnt;
`endif

  conv_wm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .start(start), .num_pass(num_pass),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb), .wt_valid(wt_valid),
    .wt_data(wt_data), .wt_last(wt_last), .wt_done(wt_done),
    .loaded(loaded), .busy(busy)
`ifdef CONV_WM_CTRL_STATS_EN
    , .ld_cnt(ld_cnt), .pass_done_cnt(pass_done_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural simple dual-port RAM, 2-cycle registered read.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_s1;
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    rd_s1     <= mem[ram_addrb];
    ram_doutb <= rd_s1;
  end

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] data; logic last; logic done; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  logic [DW-1:0] exp_mem [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_valid, gaps, done_cnt, first_vcyc, last_vcyc, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_v(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wdata(input int tag, input int i);
    logic [31:0] w;
    w = {tag[15:0], i[15:0]};
    return {16{w}};
  endfunction

  // Write monitor: every port-A write must match the next expected write.
  always @(negedge clk) begin : wmon
    wr_t e;
    if (rst_n && ram_wea) begin
      if (wr_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_write: got addr %0d expected none", ram_addra);
      end else begin
        e = wr_q.pop_front();
        check_v("wr_addr", int'(ram_addra), int'(e.addr));
        check_d("wr_data", ram_dina, e.data);
      end
    end
  end

  // Read monitor: every replayed word must match the next expected word.
  always @(negedge clk) begin : rmon
    rd_t e;
    if (rst_n && wt_valid) begin
      if (rd_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_wt_valid: got word at cycle %0d expected none", cyc);
      end else begin
        e = rd_q.pop_front();
        check_d("wt_data", wt_data, e.data);
        check_v("wt_last", int'(wt_last), int'(e.last));
        check_v("wt_done", int'(wt_done), int'(e.done));
      end
      if (n_valid == 0) first_vcyc = cyc;
      else if (cyc != last_vcyc + 1) gaps++;
      last_vcyc = cyc;
      n_valid++;
      if (wt_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_quiet(input string nm);
    check_v({nm, "_ld_ready"}, int'(ld_ready), 0);
    check_v({nm, "_ram_wea"}, int'(ram_wea), 0);
    check_v({nm, "_ram_addrb"}, int'(ram_addrb), 0);
    check_v({nm, "_wt_valid"}, int'(wt_valid), 0);
    check_v({nm, "_wt_last"}, int'(wt_last), 0);
    check_v({nm, "_wt_done"}, int'(wt_done), 0);
    check_v({nm, "_loaded"}, int'(loaded), 0);
    check_v({nm, "_busy"}, int'(busy), 0);
    check_d({nm, "_wt_data"}, wt_data, '0);
  endtask

  // Called at posedge+1. Sends nwords words; a full load checks completion.
  task automatic do_load(input int tag, input bit throttle, input int nwords, input bit send_req);
    int i, guard;
    bit fire;
    wr_t w;
    if (send_req) begin
      load_req = 1'b1;
      @(posedge clk); #1 load_req = 1'b0;
    end
    for (int k = 0; k < nwords; k++) begin
      w.addr = AW'(k);
      w.data = wdata(tag, k);
      wr_q.push_back(w);
      exp_mem[k] = wdata(tag, k);
    end
    i = 0; guard = 0;
    while (i < nwords && guard < 4 * DEPTH) begin
      ld_valid = throttle ? (guard % 2 == 0) : 1'b1;
      ld_data  = ld_valid ? wdata(tag, i) : ~wdata(tag, i);
      fire = ld_valid && ld_ready;
      if (fire && i == DEPTH - 1) check_v("loaded_before_last", int'(loaded), 0);
      @(posedge clk); #1;
      if (fire) i++;
      guard++;
    end
    ld_valid = 1'b0;
    ld_data  = '0;
    if (i < nwords) begin
      vectors++; miscompares++;
      $display("FAIL load_timeout: got %0d words expected %0d", i, nwords);
    end
    if (nwords == DEPTH) begin
      check_v("loaded_after_load", int'(loaded), 1);
      check_v("ld_ready_after_load", int'(ld_ready), 0);
      check_v("busy_after_load", int'(busy), 0);
      check_v("wr_q_drained", wr_q.size(), 0);
    end
  endtask

  // Called at posedge+1 in LOADED. Checks replay timing and count.
  task automatic do_replay(input int np, input bit poke);
    int eff, s, guard;
    rd_t e;
    eff = (np == 0) ? 1 : np;
    for (int p = 0; p < eff; p++)
      for (int a = 0; a < DEPTH; a++) begin
        e.data = exp_mem[a];
        e.last = (a == DEPTH - 1);
        e.done = (a == DEPTH - 1) && (p == eff - 1);
        rd_q.push_back(e);
      end
    n_valid = 0; gaps = 0; done_cnt = 0; first_vcyc = -1; last_vcyc = -1; done_cyc = -1;
    start = 1'b1; num_pass = PW'(np); s = cyc;
    @(posedge clk); #1 start = 1'b0; num_pass = '0;
    check_v("rd_first_addr", int'(ram_addrb), 0);
    check_v("rd_busy", int'(busy), 1);
    guard = 0;
    while (done_cnt == 0 && guard < eff * DEPTH + 50) begin
      if (poke) begin
        start    = (guard == 50);
        num_pass = (guard == 50) ? PW'(5) : '0;
        load_req = (guard == 100);
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0; load_req = 1'b0; num_pass = '0;
    if (done_cnt == 0) begin
      vectors++; miscompares++;
      $display("FAIL replay_timeout: got no wt_done expected one within %0d cycles", guard);
    end
    check_v("rd_first_valid_cyc", first_vcyc, s + 3);
    check_v("rd_done_cyc", done_cyc, s + eff * DEPTH + 2);
    check_v("rd_word_count", n_valid, eff * DEPTH);
    check_v("rd_gaps", gaps, 0);
    check_v("rd_done_count", done_cnt, 1);
    check_v("rd_busy_after", int'(busy), 0);
    check_v("rd_loaded_after", int'(loaded), 1);
    check_v("rd_q_drained", rd_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; load_req = 1'b0; ld_valid = 1'b0; ld_data = '0;
    start = 1'b0; num_pass = '0;
    repeat (3) @(posedge clk);
    #1 check_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start in IDLE is ignored
    start = 1'b1; num_pass = PW'(1);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_v("idle_start_busy", int'(busy), 0);
    check_v("idle_start_addrb", int'(ram_addrb), 0);

    do_load(1, 1'b0, DEPTH, 1'b1);       // full back-to-back load
    load_req = 1'b1;                      // reload from LOADED, throttled
    @(posedge clk); #1 load_req = 1'b0;
    check_v("reload_loaded_cleared", int'(loaded), 0);
    check_v("reload_ld_ready", int'(ld_ready), 1);
    do_load(2, 1'b1, DEPTH, 1'b0);

    do_replay(3, 1'b0);
    @(posedge clk); #1;
    do_replay(0, 1'b1);                   // also pokes start/load_req mid-READ

    // load_req and start together in LOADED: load wins
    @(posedge clk); #1 load_req = 1'b1; start = 1'b1; num_pass = PW'(2);
    @(posedge clk); #1 load_req = 1'b0; start = 1'b0; num_pass = '0;
    check_v("tie_loaded", int'(loaded), 0);
    check_v("tie_ld_ready", int'(ld_ready), 1);
    check_v("tie_busy", int'(busy), 1);
    repeat (4) @(posedge clk);
    #1 check_v("tie_addrb", int'(ram_addrb), 0);
    do_load(3, 1'b0, DEPTH, 1'b0);

    // reset during word 100 of a load
    do_load(4, 1'b0, 100, 1'b1);
    ld_valid = 1'b1; ld_data = wdata(4, 100);
    rst_n = 1'b0;
    #1 check_quiet("rst_load");
    check_v("rst_load_wr_q", wr_q.size(), 0);
    ld_valid = 1'b0; ld_data = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    start = 1'b1; num_pass = PW'(1);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_v("rst_load_start_ignored", int'(busy), 0);

    // reset mid-READ
    do_load(5, 1'b0, DEPTH, 1'b1);
    begin
      rd_t e;
      for (int p = 0; p < 2; p++)
        for (int a = 0; a < DEPTH; a++) begin
          e.data = exp_mem[a]; e.last = (a == DEPTH - 1); e.done = (a == DEPTH - 1) && (p == 1);
          rd_q.push_back(e);
        end
    end
    n_valid = 0; gaps = 0; done_cnt = 0;
    start = 1'b1; num_pass = PW'(2);
    @(posedge clk); #1 start = 1'b0; num_pass = '0;
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_quiet("rst_read");
    rd_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    start = 1'b1; num_pass = PW'(1);
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_v("rst_read_start_ignored", int'(busy), 0);
    check_v("rst_read_addrb", int'(ram_addrb), 0);
    check_v("final_wr_q", wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
